burst_cycle_ctrl: RTL
=====================

# burst_cycle_ctrl

Burst sequencer for the function generator output path. It consumes the 20-bit burst count held by the loadable burst-count register and a per-period wrap pulse from the phase accumulator. On a trigger it gates the DAC output for exactly N waveform periods, after a programmable trigger delay, and restarts the waveform at phase 0. With burst mode off it passes the output continuously.

## Interface
- No parameters; widths fixed at 20 bits.
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low; clears all state immediately.
- Burst_N  in  20  periods per burst, from burst-count register; 0 = infinite (until Stop).
- Delay_N  in  20  Clock cycles from trigger edge to burst start.
- Burst_En  in  1  1 = burst mode, 0 = continuous output.
- Trig  in  1  trigger level, already synchronous to Clock; rising edge starts burst.
- Stop  in  1  level abort.
- Cycle_End  in  1  one-Clock pulse from phase accumulator at each period wrap.
- Gate  out  1  output enable to DAC path (registered).
- Phase_Rst  out  1  one-Clock pulse forcing phase accumulator to 0 (registered).
- Busy  out  1  high in DELAY or RUN (registered).
- Done  out  1  one-Clock pulse on normal burst completion (registered).
- Remain  out  20  periods left in current burst; 0 in IDLE.

## Operation
- States: IDLE, DELAY, RUN. Internal: Trig_d (1b), dly (20b), cnt (20b), inf (1b).
- Edge = Trig & ~Trig_d; Trig_d <= Trig every cycle.
- IDLE, Burst_En=1, Edge, Stop=0: capture cnt<=Burst_N, inf<=(Burst_N==0). If Delay_N==0 -> RUN; else dly<=Delay_N -> DELAY.
- DELAY: dly decrements each cycle; on dly==1 -> RUN.
- Entry to RUN: Gate<=1, Phase_Rst<=1 for that single cycle.
- RUN: Cycle_End ignored in the Phase_Rst cycle. Otherwise Cycle_End with inf=0 decrements cnt. Cycle_End with cnt==1 -> IDLE with Gate<=0, Done<=1, cnt<=0. With inf=1, cnt stays 0 and only Stop ends the burst.
- Remain = cnt. In RUN it counts down and reaches 0 on completion.
- Trig edges in DELAY or RUN are ignored; the block is non-retriggerable.
- Stop=1 in any state: next edge -> IDLE, Gate<=0, cnt<=0, no Done. Stop beats a simultaneous Edge and a simultaneous final Cycle_End.
- Burst_En=0: next edge -> IDLE and Gate<=1 continuously; Busy=0, Done=0, Phase_Rst=0, Remain=0. Deasserting mid-burst aborts the burst with no Done.
- Burst_En=1 in IDLE: Gate=0.
- Burst_N and Delay_N are sampled only at the trigger edge. Later changes do not affect the burst in progress.

## Timing
- Reset asserted: state=IDLE; Gate, Phase_Rst, Busy, Done=0; Remain=0; Trig_d=0. After release, Gate follows ~Burst_En from the first Clock edge.
- Reset mid-burst: outputs drop immediately and asynchronously, with no Done.
- Trig sampled 0 at edge k-1 and 1 at edge k, with Delay_N=D: Gate and Phase_Rst go high after edge k+D (D=0 -> after edge k). Busy goes high after edge k.
- Final Cycle_End sampled at edge m: Gate=0, Busy=0, Done=1 after edge m. Done drops after edge m+1.
- Earliest retrigger is an Edge sampled at edge m+1.
- Burst_N=0xFFFFF and Delay_N=0xFFFFF: no overflow or wrap; counters only decrement.

## Test plan
- Burst_N=3, Delay_N=0, Cycle_End every 8 cycles, Trig edge at k -> Gate high after edge k through the 3rd Cycle_End. Remain steps 3,2,1,0. One Done pulse, one Phase_Rst at k.
- Burst_N=2, Delay_N=5 -> Busy after edge k, Gate and Phase_Rst after edge k+5. Cycle_End pulses during DELAY do not change Remain.
- Burst_N=0 (infinite), 20 Cycle_End pulses, then Stop -> Gate stays high throughout and Remain stays 0. Gate low one edge after Stop, no Done.
- Second Trig edge during RUN, and Stop coincident with the final Cycle_End -> retrigger ignored; Gate low, Done stays 0.
- Burst_En toggled 1->0 mid-burst, then 0->1 -> Gate=1 continuous with Busy=0; then Gate=0 in IDLE until the next Edge.
- Reset pulsed low mid-DELAY (between clock edges) -> all outputs 0 immediately. Next Trig edge runs a normal burst.

Source files
------------

// File: rtl/burst_cycle_ctrl.sv
// Burst sequencer for the function generator output path.
// On a trigger edge it gates the DAC for N waveform periods after a delay; with burst mode off it passes the output continuously.
module burst_cycle_ctrl (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [19:0] burst_n_i,
   input  logic [19:0] delay_n_i,
   input  logic        burst_en_i,
   input  logic        trig_i,
   input  logic        stop_i,
   input  logic        cycle_end_i,
   output logic        gate_o,
   output logic        phase_rst_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [19:0] remain_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        trig_q;
   logic [19:0] dly_q, dly_d;
   logic [19:0] cnt_q, cnt_d;
   logic        inf_q, inf_d;
   logic        gate_q, gate_d;
   logic        phase_rst_q, phase_rst_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        trig_edge_s;

   assign trig_edge_s = trig_i & ~trig_q;

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         trig_q      <= 1'b0;
         dly_q       <= 20'd0;
         cnt_q       <= 20'd0;
         inf_q       <= 1'b0;
         gate_q      <= 1'b0;
         phase_rst_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         trig_q      <= trig_i;
         dly_q       <= dly_d;
         cnt_q       <= cnt_d;
         inf_q       <= inf_d;
         gate_q      <= gate_d;
         phase_rst_q <= phase_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state and counter logic; abort paths take priority over everything else
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      cnt_d   = cnt_q;
      inf_d   = inf_q;
      if (!burst_en_i || stop_i) begin
         state_d = ST_IDLE;
         dly_d   = 20'd0;
         cnt_d   = 20'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (trig_edge_s) begin
                  cnt_d = burst_n_i;
                  inf_d = (burst_n_i == 20'd0);
                  if (delay_n_i == 20'd0) begin
                     state_d = ST_RUN;
                  end else begin
                     dly_d   = delay_n_i;
                     state_d = ST_DELAY;
                  end
               end else begin
                  cnt_d = 20'd0;
               end
            end
            ST_DELAY: begin
               if (dly_q <= 20'd1) begin
                  dly_d   = 20'd0;
                  state_d = ST_RUN;
               end else begin
                  dly_d = dly_q - 20'd1;
               end
            end
            ST_RUN: begin
               // The wrap coincident with the phase restart belongs to the old waveform
               if (cycle_end_i && !phase_rst_q && !inf_q) begin
                  if (cnt_q <= 20'd1) begin
                     cnt_d   = 20'd0;
                     state_d = ST_IDLE;
                  end else begin
                     cnt_d = cnt_q - 20'd1;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_IDLE;
               dly_d   = 20'd0;
               cnt_d   = 20'd0;
            end
         endcase
      end
   end

   // Registered output decode from the upcoming state
   always_comb begin
      gate_d      = 1'b0;
      phase_rst_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      if (!burst_en_i) begin
         gate_d = 1'b1;
      end else begin
         gate_d      = (state_d == ST_RUN);
         phase_rst_d = (state_d == ST_RUN) && (state_q != ST_RUN);
         busy_d      = (state_d != ST_IDLE);
         done_d      = !stop_i && (state_q == ST_RUN) && (state_d == ST_IDLE);
      end
   end

   assign gate_o      = gate_q;
   assign phase_rst_o = phase_rst_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign remain_o    = cnt_q;

endmodule
